// File: rtl/temperature_calculator.sv
// temperature_calculator: tempc = tc_base + adc_data / tc_ref using a 16-cycle restoring divider.
// Optional build macro TEMPCALC_SAT_ADD_EN: when defined, the final addition saturates to 0xFFFFFFFF instead of wrapping.
module temperature_calculator (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] tc_base,
    input  logic [7:0]  tc_ref,
    input  logic [15:0] adc_data,
    output logic [31:0] tempc,
    output logic [31:0] drd,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);
    typedef enum logic [1:0] {IDLE, DIV, ADD} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] base_q, base_d;
    logic [7:0]  div_q, div_d;
    logic [15:0] quo_q, quo_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] tempc_q, tempc_d;
    logic [31:0] drd_q, drd_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;
    logic [16:0] rem_sh;
    logic [15:0] diff;
    logic        ge;
    logic [31:0] sum;
    // Next-state logic: capture in IDLE, one restoring step per DIV cycle, publish results in ADD.
    // A zero divisor needs no special case: every step subtracts 0, so the quotient fills with ones
    // and the 16-bit partial remainder ends up holding the whole dividend.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        div_d   = div_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        tempc_d = tempc_q;
        drd_d   = drd_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        rem_sh  = {rem_q, quo_q[15]};
        ge      = rem_sh >= {9'b0, div_q};
        diff    = rem_sh[15:0] - {8'b0, div_q};
        sum     = base_q + {16'b0, quo_q};
        case (state_q)
            IDLE: if (start) begin
                state_d = DIV;
                cnt_d   = 4'd0;
                base_d  = tc_base;
                div_d   = tc_ref;
                quo_d   = adc_data;
                rem_d   = 16'd0;
            end
            DIV: begin
                quo_d   = {quo_q[14:0], ge};
                rem_d   = ge ? diff : rem_sh[15:0];
                cnt_d   = cnt_q + 4'd1;
                state_d = (cnt_q == 4'd15) ? ADD : DIV;
            end
            ADD: begin
`ifdef TEMPCALC_SAT_ADD_EN
                tempc_d = (sum < base_q) ? 32'hFFFF_FFFF : sum;
`else
                tempc_d = sum;
`endif
                drd_d   = {16'b0, rem_q};
                dz_d    = (div_q == 8'd0);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // State and result registers; reset aborts any calculation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            base_q  <= 32'd0;
            div_q   <= 8'd0;
            quo_q   <= 16'd0;
            rem_q   <= 16'd0;
            tempc_q <= 32'd0;
            drd_q   <= 32'd0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            tempc_q <= tempc_d;
            drd_q   <= drd_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end
    assign tempc    = tempc_q;
    assign drd      = drd_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_temperature_calculator.sv
// tb_temperature_calculator: directed vector table plus busy-ignore and mid-run reset sequences.
module tb_temperature_calculator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] tc_base = '0;
    logic [7:0]  tc_ref = '0;
    logic [15:0] adc_data = '0;
    logic [31:0] tempc, drd;
    logic        busy, done, div_zero;
    int n_run = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] b;
        logic [7:0]  r;
        logic [15:0] a;
        logic [31:0] t;
        logic [31:0] d;
        logic        z;
    } vec_t;
    vec_t vecs[8];

    temperature_calculator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tc_base(tc_base), .tc_ref(tc_ref),
        .adc_data(adc_data), .tempc(tempc), .drd(drd), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Pulse start for edge k, then scramble the inputs so capture is exercised.
    task automatic launch(input logic [31:0] b, input logic [7:0] r, input logic [15:0] a);
        @(negedge clk);
        tc_base = b; tc_ref = r; adc_data = a; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tc_base = $urandom; tc_ref = 8'($urandom); adc_data = 16'($urandom);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int lat;
        int busy_bad;
        logic [31:0] t_hold;
        launch(v.b, v.r, v.a);
        lat = 0;
        busy_bad = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (!busy) busy_bad++;
        end
        chk({nm, " latency"}, lat, 17);
        chk({nm, " busy_low_early"}, busy_bad, 0);
        chk({nm, " busy_at_done"}, {31'b0, busy}, 0);
        chk({nm, " tempc"}, tempc, v.t);
        chk({nm, " drd"}, drd, v.d);
        chk({nm, " div_zero"}, {31'b0, div_zero}, {31'b0, v.z});
        t_hold = tempc;
        repeat (3) @(posedge clk);
        #1;
        chk({nm, " done_one_cycle"}, {31'b0, done}, 0);
        chk({nm, " tempc_hold"}, tempc, t_hold);
    endtask

    initial begin
        int ndone;
        int i_done;
        logic [31:0] t_done;
        vecs[0] = '{32'd8, 8'd16, 16'd8, 32'd8, 32'd8, 1'b0};
        vecs[1] = '{32'hAAAAAAAA, 8'hC6, 16'hAAAA, 32'hAAAAAB86, 32'd130, 1'b0};
        vecs[2] = '{32'd0, 8'd0, 16'h1234, 32'h0000FFFF, 32'h1234, 1'b1};
`ifdef TEMPCALC_SAT_ADD_EN
        vecs[3] = '{32'hFFFFFFF0, 8'd1, 16'h20, 32'hFFFFFFFF, 32'd0, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 8'd0, 16'd0, 32'hFFFFFFFF, 32'd0, 1'b1};
`else
        vecs[3] = '{32'hFFFFFFF0, 8'd1, 16'h20, 32'h00000010, 32'd0, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 8'd0, 16'd0, 32'h0000FFFE, 32'd0, 1'b1};
`endif
        vecs[4] = '{32'd100, 8'd7, 16'd1000, 32'd242, 32'd6, 1'b0};
        vecs[5] = '{32'd0, 8'hFF, 16'hFFFF, 32'd257, 32'd0, 1'b0};
        vecs[6] = '{32'd5, 8'd200, 16'd199, 32'd5, 32'd199, 1'b0};

        #1 rst_n = 1'b0;
        #1;
        chk("rst tempc", tempc, 0);
        chk("rst drd", drd, 0);
        chk("rst busy", {31'b0, busy}, 0);
        chk("rst done", {31'b0, done}, 0);
        chk("rst div_zero", {31'b0, div_zero}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // start pulsed while busy and held across the done edge: one result only
        launch(32'd3, 8'd10, 16'd100);
        ndone = 0; i_done = 0; t_done = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin ndone++; i_done = i; t_done = tempc; end
            start = (i == 3 || i == 9 || i == 16);
        end
        start = 1'b0;
        chk("busy_ign done_count", ndone, 1);
        chk("busy_ign latency", i_done, 17);
        chk("busy_ign tempc", t_done, 32'd13);

        // reset at k+8 aborts without a done pulse
        launch(32'd1, 8'd3, 16'd9);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst tempc", tempc, 0);
        chk("midrst drd", drd, 0);
        chk("midrst busy", {31'b0, busy}, 0);
        chk("midrst done", {31'b0, done}, 0);
        chk("midrst div_zero", {31'b0, div_zero}, 0);
        @(negedge clk) rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("midrst no_done", ndone, 0);
        chk("midrst tempc_after", tempc, 0);

        run_vec("post_rst", vecs[4]);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/temperature_calculator.md
TEMPERATURE_CALCULATOR -- requirements
Module: TemperatureCalculator

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled on rising clk edge while idle.
REQ-005 tc_base  input  32  unsigned base temperature offset.
REQ-006 tc_ref  input  8  unsigned reference divisor.
REQ-007 adc_data  input  16  unsigned raw ADC sample (dividend).
REQ-008 tempc  output  32  registered result: tc_base + (adc_data / tc_ref).
REQ-009 drd  output  32  registered division remainder (adc_data % tc_ref), zero-extended to 32 bits.
REQ-010 busy  output  1  high while a calculation is in progress.
REQ-011 done  output  1  one-cycle pulse when tempc/drd are updated.
REQ-012 div_zero  output  1  registered flag set with done when the captured tc_ref was 0.

Function
REQ-013 States SHALL be IDLE, DIV, ADD; IDLE->DIV on start=1, DIV->ADD after 16 iterations, ADD->IDLE unconditionally.
REQ-014 At edge k with start=1 in IDLE, the block SHALL capture tc_base, tc_ref, adc_data; later input changes SHALL NOT affect the result.
REQ-015 Division SHALL be unsigned restoring, one quotient bit per cycle, MSB first, on edges k+1..k+16.
REQ-016 At edge k+17, the block SHALL write tempc, drd and div_zero, assert done for exactly one cycle, and return to IDLE.
REQ-017 busy SHALL be 1 from after edge k until edge k+17, and 0 otherwise.
REQ-018 start while busy SHALL be ignored; start asserted at the same edge done pulses SHALL also be ignored.
REQ-019 The quotient is at most 16 bits; it SHALL be zero-extended and added to tc_base modulo 2^32 (wrap-around), unless REQ-026 applies.
REQ-020 If tc_ref=0, the block SHALL keep the same latency, produce quotient 0xFFFF and remainder adc_data, and set div_zero=1.
REQ-021 tempc, drd and div_zero SHALL hold their values between done pulses.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE and set tempc=0, drd=0, busy=0, done=0 and div_zero=0.
REQ-023 Reset asserted mid-calculation SHALL abort it without producing a done pulse.
REQ-024 The first start after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-025 The macro TEMPCALC_SAT_ADD_EN SHALL select saturating addition.
REQ-026 With TEMPCALC_SAT_ADD_EN defined, tempc SHALL saturate to 0xFFFFFFFF when the 32-bit sum overflows.
REQ-027 Without TEMPCALC_SAT_ADD_EN, tempc SHALL wrap modulo 2^32.

Verification
REQ-028 tc_base=8, tc_ref=16, adc_data=8, start -> done at k+17, tempc=8, drd=8, div_zero=0.
REQ-029 tc_base=0xAAAAAAAA, tc_ref=0xC6, adc_data=0xAAAA -> tempc=0xAAAAAB86, drd=130.
REQ-030 tc_ref=0, adc_data=0x1234, tc_base=0 -> tempc=0x0000FFFF, drd=0x1234, div_zero=1, latency 17.
REQ-031 tc_base=0xFFFFFFF0, tc_ref=1, adc_data=0x20 -> tempc=0x00000010 without the macro; 0xFFFFFFFF with TEMPCALC_SAT_ADD_EN.
REQ-032 Two checks in one run:
- start re-pulsed while busy -> ignored, with exactly one done pulse.
- rst_n pulsed at k+8 -> no done pulse, all outputs 0.
